// File: rtl/alu_if.sv
// alu_if: operand/result handshake bundle between the operand stage and alu_pipe.
//   slave  (ALU side):      in_valid, a, b, funct, out_ready in; in_ready, out_valid, result, flags out
//   master (producer side): the mirror image
interface alu_if #(
    parameter int unsigned WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [5:0]       funct;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             flag_zero;
    logic             flag_carry;
    logic             flag_ovf;

    modport slave (
        input  in_valid, a, b, funct, out_ready,
        output in_ready, out_valid, result, flag_zero, flag_carry, flag_ovf
    );

    modport master (
        output in_valid, a, b, funct, out_ready,
        input  in_ready, out_valid, result, flag_zero, flag_carry, flag_ovf
    );
endinterface

// File: rtl/alu_pipe.sv
// alu_pipe: handshaked ALU with a registered result and zero/carry/overflow flags.
//   clk, rst : clock, synchronous active-high reset
//   bus      : alu_if.slave (input op port in_valid/in_ready/a/b/funct,
//              output port out_valid/out_ready/result/flag_*)
// Build option: define ALU_MUL_EN to include the iterative shift-add multiplier
// (funct 001100, WIDTH cycles busy). Without it, 001100 is an unsigned add.
module alu_pipe #(
    parameter int unsigned WIDTH = 32
) (
    input  logic clk,
    input  logic rst,
    alu_if.slave bus
);
    localparam int unsigned SW = $clog2(WIDTH);
    localparam int unsigned CW = SW + 1;

    localparam logic [5:0] OP_ADD  = 6'b000000;
    localparam logic [5:0] OP_SUB  = 6'b000001;
    localparam logic [5:0] OP_ADDU = 6'b000010;
    localparam logic [5:0] OP_SUBU = 6'b000011;
    localparam logic [5:0] OP_AND  = 6'b000100;
    localparam logic [5:0] OP_OR   = 6'b000101;
    localparam logic [5:0] OP_SLL  = 6'b000110;
    localparam logic [5:0] OP_SRL  = 6'b000111;
    localparam logic [5:0] OP_SLTU = 6'b001000;
    localparam logic [5:0] OP_SLT  = 6'b001001;
    localparam logic [5:0] OP_XOR  = 6'b001010;
    localparam logic [5:0] OP_SRA  = 6'b001011;

    logic [WIDTH:0]   add_w, sub_w;
    logic [SW-1:0]    shamt;
    logic             shift_big;
    logic [WIDTH-1:0] alu_res;
    logic             alu_c, alu_v;
    logic             ready_c, accept_c, wr_alu;

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d, carry_q, carry_d, ovf_q, ovf_d;

`ifdef ALU_MUL_EN
    localparam logic [5:0] OP_MUL = 6'b001100;

    typedef enum logic {IDLE = 1'b0, MUL = 1'b1} state_t;
    state_t           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d, mcand_q, mcand_d, mplier_q, mplier_d;
    logic [CW-1:0]    cnt_q, cnt_d;
`endif

    // Single-cycle datapath; unlisted codes fall through to unsigned add.
    always_comb begin
        add_w     = {1'b0, bus.a} + {1'b0, bus.b};
        sub_w     = {1'b0, bus.a} - {1'b0, bus.b};
        shamt     = bus.b[SW-1:0];
        shift_big = (bus.b >= WIDTH'(WIDTH));
        alu_res   = add_w[WIDTH-1:0];
        alu_c     = add_w[WIDTH];
        alu_v     = 1'b0;
        case (bus.funct)
            OP_ADD: begin
                alu_c = 1'b0;
                alu_v = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (alu_res[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = sub_w[WIDTH-1:0];
                alu_c   = 1'b0;
                alu_v   = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (alu_res[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_ADDU: ;
            OP_SUBU: begin
                alu_res = sub_w[WIDTH-1:0];
                alu_c   = sub_w[WIDTH];     // borrow out == (a < b) unsigned
            end
            OP_AND:  begin alu_res = bus.a & bus.b; alu_c = 1'b0; end
            OP_OR:   begin alu_res = bus.a | bus.b; alu_c = 1'b0; end
            OP_XOR:  begin alu_res = bus.a ^ bus.b; alu_c = 1'b0; end
            OP_SLL: begin
                alu_res = shift_big ? '0 : (bus.a << shamt);
                alu_c   = 1'b0;
            end
            OP_SRL: begin
                alu_res = shift_big ? '0 : (bus.a >> shamt);
                alu_c   = 1'b0;
            end
            OP_SRA: begin
                alu_res = shift_big ? {WIDTH{bus.a[WIDTH-1]}} : WIDTH'($signed(bus.a) >>> shamt);
                alu_c   = 1'b0;
            end
            OP_SLTU: begin
                alu_res = {{(WIDTH-1){1'b0}}, (bus.a < bus.b)};
                alu_c   = 1'b0;
            end
            OP_SLT: begin
                alu_res = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
                alu_c   = 1'b0;
            end
            default: ;
        endcase
    end

    // Accept only when idle and the output slot is empty or draining this cycle.
`ifdef ALU_MUL_EN
    assign ready_c = !rst && (state_q == IDLE) && (!valid_q || bus.out_ready);
`else
    assign ready_c = !rst && (!valid_q || bus.out_ready);
`endif
    assign accept_c = bus.in_valid && ready_c;

    // Next-state: FSM, multiplier iteration and output slot.
    always_comb begin
        valid_d  = valid_q;
        result_d = result_q;
        zero_d   = zero_q;
        carry_d  = carry_q;
        ovf_d    = ovf_q;
        wr_alu   = 1'b0;
`ifdef ALU_MUL_EN
        state_d  = state_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
`endif

        if (valid_q && bus.out_ready) valid_d = 1'b0;

`ifdef ALU_MUL_EN
        case (state_q)
            IDLE: begin
                if (accept_c) begin
                    if (bus.funct == OP_MUL) begin
                        acc_d    = '0;
                        mcand_d  = bus.a;
                        mplier_d = bus.b;
                        cnt_d    = '0;
                        state_d  = MUL;
                    end else begin
                        wr_alu = 1'b1;
                    end
                end
            end
            MUL: begin
                acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_d == CW'(WIDTH)) begin
                    result_d = acc_d;
                    zero_d   = (acc_d == '0);
                    carry_d  = 1'b0;
                    ovf_d    = 1'b0;
                    valid_d  = 1'b1;
                    state_d  = IDLE;
                end
            end
        endcase
`else
        wr_alu = accept_c;
`endif

        if (wr_alu) begin
            result_d = alu_res;
            zero_d   = (alu_res == '0);
            carry_d  = alu_c;
            ovf_d    = alu_v;
            valid_d  = 1'b1;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q  <= 1'b0;
            result_q <= '0;
            zero_q   <= 1'b0;
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
`ifdef ALU_MUL_EN
            state_q  <= IDLE;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
`endif
        end else begin
            valid_q  <= valid_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            carry_q  <= carry_d;
            ovf_q    <= ovf_d;
`ifdef ALU_MUL_EN
            state_q  <= state_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
`endif
        end
    end

    assign bus.in_ready   = ready_c;
    assign bus.out_valid  = valid_q;
    assign bus.result     = result_q;
    assign bus.flag_zero  = zero_q;
    assign bus.flag_carry = carry_q;
    assign bus.flag_ovf   = ovf_q;
endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed vectors for alu_pipe; expected results are queued at
// accept and a negedge monitor pops/compares on every output transfer.
module tb_alu_pipe;
    localparam int unsigned W = 32;

    localparam logic [5:0] F_ADD  = 6'b000000;
    localparam logic [5:0] F_SUB  = 6'b000001;
    localparam logic [5:0] F_ADDU = 6'b000010;
    localparam logic [5:0] F_SUBU = 6'b000011;
    localparam logic [5:0] F_AND  = 6'b000100;
    localparam logic [5:0] F_OR   = 6'b000101;
    localparam logic [5:0] F_SLL  = 6'b000110;
    localparam logic [5:0] F_SRL  = 6'b000111;
    localparam logic [5:0] F_SLTU = 6'b001000;
    localparam logic [5:0] F_SLT  = 6'b001001;
    localparam logic [5:0] F_XOR  = 6'b001010;
    localparam logic [5:0] F_SRA  = 6'b001011;
    localparam logic [5:0] F_MUL  = 6'b001100;

    typedef struct packed {
        logic [W-1:0] res;
        logic         z;
        logic         c;
        logic         v;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_if #(.WIDTH(W)) bus ();
    alu_pipe #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    exp_t sbq[$];
    int   pop_cyc[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic [W-1:0] r, input logic z, input logic c, input logic v);
        exp_t e;
        e.res = r;
        e.z   = z;
        e.c   = c;
        e.v   = v;
        return e;
    endfunction

    // Monitor: compare every output transfer against the scoreboard head.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && bus.out_valid && bus.out_ready) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got %h expected none", bus.result);
            end else begin
                e = sbq.pop_front();
                check("result", bus.result, e.res);
                check("zero",   W'(bus.flag_zero),  W'(e.z));
                check("carry",  W'(bus.flag_carry), W'(e.c));
                check("ovf",    W'(bus.flag_ovf),   W'(e.v));
            end
            pop_cyc.push_back(cyc);
        end
    end

    // Offer one op; returns 1 ns after the accepting edge.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic [5:0] f,
                         input exp_t e, input bit push);
        bit ok;
        ok = 1'b0;
        bus.in_valid = 1'b1;
        bus.a        = a;
        bus.b        = b;
        bus.funct    = f;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (bus.in_ready) ok = 1'b1;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got in_ready=0 expected 1 (funct %b)", f);
        end else begin
            if (push) sbq.push_back(e);
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
    endtask

    initial begin
        int bad;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.a         = '0;
        bus.b         = '0;
        bus.funct     = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", W'(bus.out_valid), '0);
        check("rst_result",    bus.result, '0);
        check("rst_flags",     W'({bus.flag_zero, bus.flag_carry, bus.flag_ovf}), '0);
        check("rst_in_ready",  W'(bus.in_ready), '0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("idle_in_ready", W'(bus.in_ready), W'(1'b1));
        @(posedge clk); #1;

        // Signed overflow plus first-result latency.
        issue(32'h7FFF_FFFF, 32'h1, F_ADD, mk(32'h8000_0000, 0, 0, 1), 1);
        @(negedge clk);
        check("add_latency", W'(bus.out_valid), W'(1'b1));
        @(posedge clk); #1;

        issue(32'd3,         32'd5,       F_SUBU, mk(32'hFFFF_FFFE, 0, 1, 0), 1);
        issue(32'hFFFF_FFFF, 32'd1,       F_SLT,  mk(32'h1,         0, 0, 0), 1);
        issue(32'hFFFF_FFFF, 32'd1,       F_SLTU, mk(32'h0,         1, 0, 0), 1);
        issue(32'h8000_0000, 32'd1,       F_SUB,  mk(32'h7FFF_FFFF, 0, 0, 1), 1);
        issue(32'hFFFF_FFFF, 32'd1,       F_ADDU, mk(32'h0,         1, 1, 0), 1);
        issue(32'h0000_F0F0, 32'h0000_FF00, F_AND, mk(32'h0000_F000, 0, 0, 0), 1);
        issue(32'h0000_F0F0, 32'h0000_FF00, F_OR,  mk(32'h0000_FFF0, 0, 0, 0), 1);
        issue(32'h0000_F0F0, 32'h0000_FF00, F_XOR, mk(32'h0000_0FF0, 0, 0, 0), 1);
        issue(32'h8000_0000, 32'd40,      F_SRA,  mk(32'hFFFF_FFFF, 0, 0, 0), 1);
        issue(32'h8000_0000, 32'd4,       F_SRA,  mk(32'hF800_0000, 0, 0, 0), 1);
        issue(32'h1,         32'd32,      F_SLL,  mk(32'h0,         1, 0, 0), 1);
        issue(32'h1,         32'd31,      F_SLL,  mk(32'h8000_0000, 0, 0, 0), 1);
        issue(32'hF0,        32'd4,       F_SRL,  mk(32'h0F,        0, 0, 0), 1);
        issue(32'hF0,        32'd33,      F_SRL,  mk(32'h0,         1, 0, 0), 1);
        issue(32'd5,         32'd6,       6'b111111, mk(32'd11,     0, 0, 0), 1);

        // Four back-to-back adds drain on consecutive cycles.
        issue(32'd1,         32'd1,         F_ADD, mk(32'd2,         0, 0, 0), 1);
        issue(32'd2,         32'd2,         F_ADD, mk(32'd4,         0, 0, 0), 1);
        issue(32'd10,        32'd20,        F_ADD, mk(32'd30,        0, 0, 0), 1);
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, F_ADD, mk(32'hFFFF_FFFE, 0, 0, 0), 1);
        @(negedge clk); #1;
        check("b2b_spacing", W'(pop_cyc[pop_cyc.size()-1] - pop_cyc[pop_cyc.size()-4]), W'(3));

        // Back-pressure: result holds and input is refused.
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        issue(32'd100, 32'd23, F_ADD, mk(32'd123, 0, 0, 0), 1);
        bus.in_valid = 1'b1;
        bus.a        = 32'd1;
        bus.b        = 32'd1;
        bus.funct    = F_ADD;
        bad = 0;
        repeat (3) begin
            @(negedge clk);
            if (bus.result !== 32'd123 || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) bad++;
        end
        check("stall_hold", W'(bad), '0);
        @(posedge clk); #1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;

`ifdef ALU_MUL_EN
        // Multiply: busy for WIDTH edges, result on the edge where the count completes.
        issue(32'h0000_FFFF, 32'h0001_0001, F_MUL, mk(32'hFFFF_FFFF, 0, 0, 0), 1);
        bad = 0;
        for (int k = 0; k < int'(W); k++) begin
            @(negedge clk);
            if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0) bad++;
        end
        check("mul_busy", W'(bad), '0);
        @(negedge clk);
        check("mul_latency", W'(bus.out_valid), W'(1'b1));
        @(posedge clk); #1;

        // Reset mid-multiply: aborted op never reaches the output.
        issue(32'd3, 32'd5, F_MUL, mk(32'd15, 0, 0, 0), 0);
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check("mulrst_out_valid", W'(bus.out_valid), '0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("mulrst_idle", W'(bus.in_ready), W'(1'b1));
        check("mulrst_no_out", W'(bus.out_valid), '0);
        repeat (int'(W) + 5) @(posedge clk);
        #1;
        issue(32'd2, 32'd3, F_ADD, mk(32'd5, 0, 0, 0), 1);
        @(negedge clk);
        check("post_rst_add_latency", W'(bus.out_valid), W'(1'b1));
        @(posedge clk); #1;
`else
        // Without the multiplier, 001100 is a single-cycle unsigned add.
        issue(32'hFFFF_FFFF, 32'd2, F_MUL, mk(32'h1, 0, 1, 0), 1);
        @(negedge clk);
        check("mulcode_latency", W'(bus.out_valid), W'(1'b1));
        @(posedge clk); #1;
`endif

        for (int i = 0; i < 50 && sbq.size() != 0; i++) @(posedge clk);
        @(negedge clk); #1;
        check("scoreboard_drained", W'(sbq.size()), '0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
